intpol2_d4_seq_mult_nch: RTL

//  - NCH-channel sequential multiplier y[c] = x[c] * k built from repeated addition (one add per clock).
//  - Scales interpolator samples by an integer step count without a hard multiplier.
//  - All channels share one controller, one k and one start/busy/done handshake.
//  - Sits between the D4 coefficient path and the interpolation accumulator stage.

---
 rtl/intpol2_d4_seq_mult_nch_if.sv | 22 ++
 rtl/intpol2_d4_seq_mult_nch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/intpol2_d4_seq_mult_nch_if.sv
// Handshake/data bundle for the NCH-channel sequential multiplier.
// The controller side (master) drives start/clear/k/x. The multiplier (slave) returns busy/done/y/ovf.
interface intpol2_d4_seq_mult_nch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_bits     = 2,
    parameter int NCH        = 4,
    parameter int K_WIDTH    = 8
);
    localparam int W = DATA_WIDTH + N_bits;

    logic                 clear;
    logic                 start;
    logic [K_WIDTH-1:0]   k;
    logic [NCH*W-1:0]     x;
    logic                 busy;
    logic                 done;
    logic [NCH*W-1:0]     y;
    logic [NCH-1:0]       ovf;

    modport master (output clear, start, k, x, input  busy, done, y, ovf);
    modport slave  (input  clear, start, k, x, output busy, done, y, ovf);
endinterface

// File: rtl/intpol2_d4_seq_mult_nch.sv
// NCH-channel y = x*k by repeated addition, one add per clock. done pulses k+1 cycles after accept, and start is ignored while busy.
// Define INTPOL2_D4_SATURATE_EN to clamp on overflow; the default build wraps modulo 2^W.
module intpol2_d4_seq_mult_nch #(
    parameter int DATA_WIDTH = 32,
    parameter int N_bits     = 2,
    parameter int NCH        = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    intpol2_d4_seq_mult_nch_if.slave    bus
);
    localparam int W = DATA_WIDTH + N_bits;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [K_WIDTH-1:0]     r_k;
    logic [K_WIDTH-1:0]     r_count;
    logic signed [W-1:0]    r_x   [NCH];
    logic signed [W-1:0]    r_acc [NCH];
    logic [NCH*W-1:0]       r_y;
    logic [NCH-1:0]         r_ovf;

    logic signed [W-1:0]    w_sum  [NCH];
    logic signed [W-1:0]    w_next [NCH];
    logic [NCH-1:0]         w_ov;
    logic [NCH*W-1:0]       w_fin;
    logic                   w_last;

`ifdef INTPOL2_D4_SATURATE_EN
    localparam logic [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_sum[c] = r_acc[c] + r_x[c];
        // Overflow: operands share a sign that the sum does not.
        assign w_ov[c]  = (r_acc[c][W-1] == r_x[c][W-1]) && (w_sum[c][W-1] != r_x[c][W-1]);
`ifdef INTPOL2_D4_SATURATE_EN
        assign w_next[c] = w_ov[c] ? (r_x[c][W-1] ? W_MIN : W_MAX) : w_sum[c];
`else
        assign w_next[c] = w_sum[c];
`endif
        assign w_fin[c*W +: W] = w_next[c];
    end

    assign w_last = (r_count == (r_k - K_WIDTH'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_k     <= '0;
            r_count <= '0;
            r_y     <= '0;
            r_ovf   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_x[c]   <= '0;
                r_acc[c] <= '0;
            end
        end else if (bus.clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_k     <= '0;
            r_count <= '0;
            r_y     <= '0;
            r_ovf   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_x[c]   <= '0;
                r_acc[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_k     <= bus.k;
                        r_count <= '0;
                        r_ovf   <= '0;
                        r_busy  <= 1'b1;
                        for (int c = 0; c < NCH; c++) begin
                            r_x[c]   <= bus.x[c*W +: W];
                            r_acc[c] <= '0;
                        end
                        if (bus.k == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_y     <= '0;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    for (int c = 0; c < NCH; c++) begin
                        r_acc[c] <= w_next[c];
                    end
                    r_ovf   <= r_ovf | w_ov;
                    r_count <= r_count + K_WIDTH'(1);
                    // y is loaded with the final sum so it appears together with done.
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_y     <= w_fin;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.y    = r_y;
    assign bus.ovf  = r_ovf;
endmodule
